stochastic_compute_engine: RTL

Parametrised successor to the fixed-function stochastic REPL datapath. It accepts a command carrying an operation code, operand probabilities and a stream length, then generates seeded LFSR bitstreams. It applies the selected stochastic operation for exactly the requested number of cycles and returns the ones-count through a valid/ready result handshake. It sits between the UART command parser and the result formatter.

---
 rtl/stochastic_compute_engine_pkg.sv | 36 +++
 rtl/stochastic_compute_engine_if.sv | 35 +++
 rtl/stochastic_compute_engine_sng.sv | 37 +++
 rtl/stochastic_compute_engine.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/stochastic_compute_engine_pkg.sv
// Shared definitions for the stochastic compute engine: op codes, FSM states
// and the maximal-length LFSR tap table.
package stochastic_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND  = 2'd0;
  localparam op_t OP_MUX  = 2'd1;
  localparam op_t OP_XNOR = 2'd2;
  localparam op_t OP_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fibonacci feedback masks (bit k set = tap x^(k+1)), widths 8..16.
  function automatic logic [15:0] lfsr_taps(input int pw);
    logic [15:0] mask;
    case (pw)
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0829;
      13:      mask = 16'h100D;
      14:      mask = 16'h2015;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = 16'h00B8;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/stochastic_compute_engine_if.sv
// Command and result channels of the stochastic compute engine, with the
// status flags, grouped so the parser/formatter side connects in one port.
interface stochastic_compute_engine_if
  import stochastic_pkg::*;
#(
  parameter int PW    = 8,
  parameter int CNT_W = 16
);

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [PW-1:0]    cmd_prob_a;
  logic [PW-1:0]    cmd_prob_b;
  logic [PW-1:0]    cmd_prob_c;
  logic [CNT_W-1:0] cmd_len;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             busy;
  logic             error;

  modport master (
    output cmd_valid, cmd_op, cmd_prob_a, cmd_prob_b, cmd_prob_c, cmd_len,
    output res_ready,
    input  cmd_ready, res_valid, res_count, busy, error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_prob_a, cmd_prob_b, cmd_prob_c, cmd_len,
    input  res_ready,
    output cmd_ready, res_valid, res_count, busy, error
  );

endinterface

// File: rtl/stochastic_compute_engine_sng.sv
// Stochastic number generator: a seeded maximal-length Fibonacci LFSR whose
// output bit is one when the current state does not exceed the probability.
module stochastic_lfsr_sng
  import stochastic_pkg::*;
#(
  parameter int            PW   = 8,
  parameter logic [PW-1:0] SEED = 8'hA5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [PW-1:0] i_prob,
  output logic          o_bit
);

  localparam logic [15:0]   TAPS_ALL = lfsr_taps(PW);
  localparam logic [PW-1:0] TAPS     = TAPS_ALL[PW-1:0];

  logic [PW-1:0] r_state;
  logic          w_fb;

  assign w_fb  = ^(r_state & TAPS);
  assign o_bit = (r_state <= i_prob);

  // Load wins over step so every legal command starts from the same seed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= {r_state[PW-2:0], w_fb};
    end
  end

endmodule

// File: rtl/stochastic_compute_engine.sv
// Stochastic compute engine: latches a command, runs three seeded SNG streams
// through the selected op for cmd_len cycles and returns the ones-count.
module stochastic_compute_engine
  import stochastic_pkg::*;
#(
  parameter int            PW     = 8,
  parameter int            CNT_W  = 16,
  parameter logic [PW-1:0] SEED_A = 8'hA5,
  parameter logic [PW-1:0] SEED_B = 8'h3C,
  parameter logic [PW-1:0] SEED_C = 8'h96
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  stochastic_compute_engine_if.slave   bus
);

  state_e           r_state;
  state_e           w_next_state;
  op_t              r_op;
  logic [PW-1:0]    r_prob_a;
  logic [PW-1:0]    r_prob_b;
  logic [PW-1:0]    r_prob_c;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_count;
  logic             r_error;

  logic             w_accept;
  logic             w_legal;
  logic             w_load;
  logic             w_step;
  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_bit_c;
  logic             w_res_bit;

  stochastic_lfsr_sng #(.PW(PW), .SEED(SEED_A)) u_sng_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_prob  (r_prob_a),
    .o_bit   (w_bit_a)
  );

  stochastic_lfsr_sng #(.PW(PW), .SEED(SEED_B)) u_sng_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_prob  (r_prob_b),
    .o_bit   (w_bit_b)
  );

  stochastic_lfsr_sng #(.PW(PW), .SEED(SEED_C)) u_sng_c (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_prob  (r_prob_c),
    .o_bit   (w_bit_c)
  );

  always_comb begin
    w_res_bit = 1'b0;
    case (r_op)
      OP_AND:  w_res_bit = w_bit_a & w_bit_b;
      OP_MUX:  w_res_bit = w_bit_c ? w_bit_a : w_bit_b;
      OP_XNOR: w_res_bit = ~(w_bit_a ^ w_bit_b);
      default: w_res_bit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // RUN spends one extra cycle with nothing left to count before DONE.
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_legal       = 1'b0;
    w_step        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        w_accept      = bus.cmd_valid;
        w_legal       = (bus.cmd_op != OP_RSVD) && (bus.cmd_len != '0);
        if (w_accept && w_legal) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_remaining != '0) begin
          w_step = 1'b1;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_load = w_accept && w_legal;

  // An illegal accept only raises the error flag; nothing else is latched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op        <= OP_AND;
      r_prob_a    <= '0;
      r_prob_b    <= '0;
      r_prob_c    <= '0;
      r_remaining <= '0;
      r_count     <= '0;
      r_error     <= 1'b0;
    end else if (w_load) begin
      r_op        <= bus.cmd_op;
      r_prob_a    <= bus.cmd_prob_a;
      r_prob_b    <= bus.cmd_prob_b;
      r_prob_c    <= bus.cmd_prob_c;
      r_remaining <= bus.cmd_len;
      r_count     <= '0;
      r_error     <= 1'b0;
    end else if (w_accept) begin
      r_error     <= 1'b1;
    end else if (w_step) begin
      r_count     <= r_count + {{(CNT_W-1){1'b0}}, w_res_bit};
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign bus.res_count = r_count;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.error     = r_error;

endmodule
